dbus_decoder_n: RTL and testbench
=================================

Name: dbus_decoder_n

Overview:
- Parametrised CPU data-bus decoder/multiplexer for the single-master data bus. It replaces the fixed six-slave decoder.
- Slave count, data width and address map are set by parameters.
- Adds unmapped-address detection, a slave-stall watchdog with forced abort, and error capture registers. The interrupt/exception logic reads these registers.
- Sits between the CPU data port and the slaves: BIOS memory, VRAMs, GPIO, SD, and future peripherals.

Parameters:
- N_SLAVES, 6, number of slave ports (1..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- BASE, packed N_SLAVES*ADDR_W, slave i base address in bits [i*ADDR_W +: ADDR_W]
- MASK, packed N_SLAVES*ADDR_W, slave i compare mask; a bit set to 1 takes part in the compare
- TIMEOUT, 255, maximum consecutive stall cycles before abort; 0 disables the watchdog
- CNT_W, 16, width of the error counter

Ports:
- clk, input, 1, system clock
- rst, input, 1, synchronous active-high reset
- addrBus, input, ADDR_W, CPU address
- masterEN, input, 1, CPU access request
- dataToCPU, output, DATA_W, read data returned to the CPU
- nakDBus, output, 1, stall request to the CPU
- slvEN, output, N_SLAVES, one-hot slave select (combinational)
- slvData, input, N_SLAVES*DATA_W, slave read data; slave i occupies [i*DATA_W +: DATA_W]
- slvNak, input, N_SLAVES, per-slave stall
- busErr, output, 1, one-cycle error pulse, aligned with the aborted data phase
- errCode, output, 2, last error: 00 none, 01 unmapped, 10 timeout
- errAddr, output, ADDR_W, address of the last errored access
- errCount, output, CNT_W, saturating count of errors

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Decode (combinational):
  - hit[i] = masterEN & ((addrBus & MASK_i) == (BASE_i & MASK_i)).
  - On overlap the lowest index wins, so slvEN is always one-hot or zero.
  - miss = masterEN & ~|hit.
- Address phase registers: sel_reg (one-hot), miss_reg, addr_reg.
  - Loaded from slvEN, miss and addrBus on every clk where nakDBus == 0.
  - Held while nakDBus == 1.
  - The CPU must hold addrBus and masterEN stable while stalled.
- Data phase: one-cycle latency.
  - dataToCPU = slvData of the slave selected by sel_reg.
  - dataToCPU = 0 when sel_reg is zero, when miss_reg is set, or when the watchdog fires.
- Stall: nakDBus = |(sel_reg & slvNak) & ~wd_fire.
- Watchdog:
  - wcnt (width clog2(TIMEOUT+1)) clears whenever nakDBus == 0 and increments each cycle nakDBus == 1.
  - wd_fire = (TIMEOUT != 0) & (wcnt == TIMEOUT) & |(sel_reg & slvNak).
  - On wd_fire: nakDBus is forced 0, dataToCPU = 0, busErr = 1, errCode = 10, errAddr = addr_reg. The registers then reload normally, abandoning the stalled slave.
- Unmapped access: in the data phase with miss_reg = 1: busErr = 1, errCode = 01, errAddr = addr_reg, nakDBus = 0, dataToCPU = 0.
- Error registers:
  - errCode and errAddr update only on a new error and are otherwise sticky.
  - errCount increments on each busErr and saturates at all-ones.
  - busErr is combinational from miss_reg or wd_fire, so it stays high for exactly one cycle per error.
- Idle: masterEN low with no stall loads sel_reg = 0, so the next cycle gives dataToCPU = 0 and nakDBus = 0.
- Reset values: sel_reg 0, miss_reg 0, addr_reg 0, wcnt 0, errCode 00, errAddr 0, errCount 0. Outputs are therefore dataToCPU 0, nakDBus 0, busErr 0.
- Reset during a stall: nakDBus is 0 on the cycle after rst is sampled, and the pending access is dropped without raising an error.
- Slave nak after its data phase: ignored, because sel_reg no longer selects that slave.

Test Plan:
1. Default map (BIOS 0xbfc00000/mask 0x1fffc000, gVRAM 0xbfe00000/mask 0x1fe00000):
   - masterEN=1, addr 0xbfc00010 → slvEN = 000001 that cycle; next cycle dataToCPU = BIOS data, busErr = 0.
   - Back-to-back accesses BIOS→gVRAM→GPIO → each response appears one cycle later from the correct slave.
2. Stall:
   - Select gVRAM; gVramNak high for 3 cycles → nakDBus high for exactly 3 cycles and sel_reg held.
   - The new address presented during the stall does not load until nak drops; then data is correct.
3. Unmapped: addr 0xbfc0a000 → slvEN = 0; next cycle busErr = 1 for one cycle, errCode = 01, errAddr = 0xbfc0a000, dataToCPU = 0, errCount = 1.
4. Watchdog:
   - TIMEOUT = 4, slave nak held high → nakDBus high 4 cycles, then low with busErr = 1, errCode = 10, dataToCPU = 0.
   - TIMEOUT = 0 with the same stimulus → nakDBus stays high indefinitely.
5. Overlap: BASE0 = BASE1 → only slvEN[0] asserts.
6. Saturation and reset:
   - CNT_W = 2, 5 errors → errCount = 3.
   - rst during a stall → nakDBus = 0 and all error registers = 0 the next cycle.

Source files
------------

// File: rtl/dbus_decoder_n.sv
// Parametrised data-bus decoder/mux for the single-master CPU data bus.
// Address decode with lowest-index priority, one-cycle data phase, stall
// forwarding, stall watchdog with forced abort, and error capture registers.
module dbus_decoder_n #(
    parameter int unsigned N_SLAVES = 6,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] BASE = {
        32'hbfd10000, 32'hbfd02000, 32'hbfd01000,
        32'hbfd00000, 32'hbfe00000, 32'hbfc00000},
    parameter logic [N_SLAVES*ADDR_W-1:0] MASK = {
        32'h1fff0000, 32'h1ffff000, 32'h1ffff000,
        32'h1ffff000, 32'h1fe00000, 32'h1fffc000},
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          addrBus,
    input  logic                       masterEN,
    output logic [DATA_W-1:0]          dataToCPU,
    output logic                       nakDBus,
    output logic [N_SLAVES-1:0]        slvEN,
    input  logic [N_SLAVES*DATA_W-1:0] slvData,
    input  logic [N_SLAVES-1:0]        slvNak,
    output logic                       busErr,
    output logic [1:0]                 errCode,
    output logic [ADDR_W-1:0]          errAddr,
    output logic [CNT_W-1:0]           errCount
);

    // A zero TIMEOUT still needs a legal (unused) counter width.
    localparam int unsigned WCNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    logic [N_SLAVES-1:0] hit;
    logic [N_SLAVES-1:0] slv_en;
    logic                miss;

    logic [N_SLAVES-1:0] sel_q,      sel_d;
    logic                miss_q,     miss_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [WCNT_W-1:0]   wcnt_q,     wcnt_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic [CNT_W-1:0]    err_cnt_q,  err_cnt_d;

    logic                stall_raw;
    logic                wd_fire;
    logic                nak;
    logic                bus_err;
    logic [DATA_W-1:0]   rdata;

    // Address decode; scanning downward lets the lowest matching index win.
    always_comb begin
        hit    = '0;
        slv_en = '0;
        for (int i = 0; i < int'(N_SLAVES); i++) begin
            hit[i] = masterEN &&
                     ((addrBus & MASK[i*ADDR_W +: ADDR_W]) ==
                      (BASE[i*ADDR_W +: ADDR_W] & MASK[i*ADDR_W +: ADDR_W]));
        end
        for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
            if (hit[i]) begin
                slv_en = N_SLAVES'(1) << i;
            end
        end
        miss = masterEN && !(|hit);
    end

    // Data phase: stall forwarding, watchdog abort and read-data mux.
    always_comb begin
        stall_raw = |(sel_q & slvNak);
        wd_fire   = (TIMEOUT != 0) && (wcnt_q == WCNT_W'(TIMEOUT)) && stall_raw;
        nak       = stall_raw && !wd_fire;
        bus_err   = miss_q || wd_fire;
        rdata     = '0;
        for (int i = 0; i < int'(N_SLAVES); i++) begin
            if (sel_q[i]) begin
                rdata = rdata | slvData[i*DATA_W +: DATA_W];
            end
        end
        if (miss_q || wd_fire) begin
            rdata = '0;
        end
    end

    // Next state: address-phase capture, watchdog count, error capture.
    always_comb begin
        sel_d      = sel_q;
        miss_d     = miss_q;
        addr_d     = addr_q;
        wcnt_d     = wcnt_q;
        err_code_d = err_code_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        if (!nak) begin
            sel_d  = slv_en;
            miss_d = miss;
            addr_d = addrBus;
            wcnt_d = '0;
        end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
        end
        if (bus_err) begin
            err_code_d = wd_fire ? 2'b10 : 2'b01;
            err_addr_d = addr_q;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q      <= '0;
            miss_q     <= 1'b0;
            addr_q     <= '0;
            wcnt_q     <= '0;
            err_code_q <= 2'b00;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            sel_q      <= sel_d;
            miss_q     <= miss_d;
            addr_q     <= addr_d;
            wcnt_q     <= wcnt_d;
            err_code_q <= err_code_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign slvEN     = slv_en;
    assign dataToCPU = rdata;
    assign nakDBus   = nak;
    assign busErr    = bus_err;
    assign errCode   = err_code_q;
    assign errAddr   = err_addr_q;
    assign errCount  = err_cnt_q;

endmodule

// File: tb/tb_dbus_decoder_n.sv
// Bench for dbus_decoder_n: two instances (watchdog 4 / 2-bit counter, and
// watchdog off / overlapping map) driven together and checked per cycle
// against a transaction-level model of the bus.
module tb_dbus_decoder_n;

    localparam logic [191:0] BASE_A = {
        32'hbfd10000, 32'hbfd02000, 32'hbfd01000,
        32'hbfd00000, 32'hbfe00000, 32'hbfc00000};
    localparam logic [191:0] MASK_A = {
        32'h1fff0000, 32'h1ffff000, 32'h1ffff000,
        32'h1ffff000, 32'h1fe00000, 32'h1fffc000};
    localparam logic [191:0] BASE_B = {BASE_A[191:64], BASE_A[31:0], BASE_A[31:0]};
    localparam logic [191:0] MASK_B = {MASK_A[191:64], MASK_A[31:0], MASK_A[31:0]};

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr_bus;
    logic         master_en;
    logic [191:0] slv_data;
    logic [5:0]   slv_nak;

    logic [31:0]  a_data, b_data, a_eaddr, b_eaddr;
    logic         a_nak, b_nak, a_err, b_err;
    logic [5:0]   a_en, b_en;
    logic [1:0]   a_code, b_code;
    logic [1:0]   a_cnt;
    logic [15:0]  b_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model state per instance: pending access (-1 idle, -2 unmapped, else slave).
    int          pend  [2];
    logic [31:0] paddr [2];
    int          scnt  [2];
    logic [1:0]  ecode [2];
    logic [31:0] eaddr [2];
    int          ecnt  [2];
    logic        mnak  [2];

    dbus_decoder_n #(.N_SLAVES(6), .ADDR_W(32), .DATA_W(32), .BASE(BASE_A),
                     .MASK(MASK_A), .TIMEOUT(4), .CNT_W(2)) u_a (
        .clk(clk), .rst(rst), .addrBus(addr_bus), .masterEN(master_en),
        .dataToCPU(a_data), .nakDBus(a_nak), .slvEN(a_en), .slvData(slv_data),
        .slvNak(slv_nak), .busErr(a_err), .errCode(a_code), .errAddr(a_eaddr),
        .errCount(a_cnt));

    dbus_decoder_n #(.N_SLAVES(6), .ADDR_W(32), .DATA_W(32), .BASE(BASE_B),
                     .MASK(MASK_B), .TIMEOUT(0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .addrBus(addr_bus), .masterEN(master_en),
        .dataToCPU(b_data), .nakDBus(b_nak), .slvEN(b_en), .slvData(slv_data),
        .slvNak(slv_nak), .busErr(b_err), .errCode(b_code), .errAddr(b_eaddr),
        .errCount(b_cnt));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            pend[m] = -1; paddr[m] = '0; scnt[m] = 0;
            ecode[m] = 2'b00; eaddr[m] = '0; ecnt[m] = 0; mnak[m] = 1'b0;
        end
    endtask

    // Predict this cycle's outputs of instance m, compare, then advance the model.
    task automatic model_step(input int m);
        logic [191:0] base, mask;
        int           tmo, cmax, widx;
        logic [31:0]  g_data, g_eaddr, e_data;
        logic         g_nak, g_err, stalling, fire, e_nak, e_err;
        logic [5:0]   g_en, e_en;
        logic [1:0]   g_code;
        int           g_cnt;
        if (m == 0) begin
            base = BASE_A; mask = MASK_A; tmo = 4; cmax = 3;
            g_data = a_data; g_nak = a_nak; g_err = a_err; g_en = a_en;
            g_code = a_code; g_eaddr = a_eaddr; g_cnt = int'(a_cnt);
        end else begin
            base = BASE_B; mask = MASK_B; tmo = 0; cmax = 65535;
            g_data = b_data; g_nak = b_nak; g_err = b_err; g_en = b_en;
            g_code = b_code; g_eaddr = b_eaddr; g_cnt = int'(b_cnt);
        end
        widx = -1;
        for (int i = 0; i < 6; i++) begin
            if (widx < 0 && master_en &&
                ((addr_bus & mask[i*32 +: 32]) == (base[i*32 +: 32] & mask[i*32 +: 32])))
                widx = i;
        end
        e_en     = (widx >= 0) ? (6'd1 << widx) : 6'd0;
        stalling = (pend[m] >= 0) && slv_nak[pend[m]];
        fire     = (tmo != 0) && stalling && (scnt[m] == tmo);
        e_nak    = stalling && !fire;
        e_err    = (pend[m] == -2) || fire;
        e_data   = (pend[m] >= 0 && !fire) ? slv_data[pend[m]*32 +: 32] : 32'd0;

        chk($sformatf("slvEN%0d", m),     64'(g_en),    64'(e_en));
        chk($sformatf("nakDBus%0d", m),   64'(g_nak),   64'(e_nak));
        chk($sformatf("busErr%0d", m),    64'(g_err),   64'(e_err));
        chk($sformatf("dataToCPU%0d", m), 64'(g_data),  64'(e_data));
        chk($sformatf("errCode%0d", m),   64'(g_code),  64'(ecode[m]));
        chk($sformatf("errAddr%0d", m),   64'(g_eaddr), 64'(eaddr[m]));
        chk($sformatf("errCount%0d", m),  64'(g_cnt),   64'(ecnt[m]));

        mnak[m] = e_nak;
        if (rst) begin
            pend[m] = -1; paddr[m] = '0; scnt[m] = 0;
            ecode[m] = 2'b00; eaddr[m] = '0; ecnt[m] = 0;
        end else begin
            if (e_err) begin
                ecode[m] = fire ? 2'b10 : 2'b01;
                eaddr[m] = paddr[m];
                if (ecnt[m] < cmax) ecnt[m]++;
            end
            if (!e_nak) begin
                pend[m]  = (widx >= 0) ? widx : (master_en ? -2 : -1);
                paddr[m] = addr_bus;
                scnt[m]  = 0;
            end else begin
                scnt[m]++;
            end
        end
    endtask

    // Per-cycle checking on the falling edge, inputs stable.
    always @(negedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic drive(input logic r, input logic en, input logic [31:0] a, input logic [5:0] nk);
        rst = r; master_en = en; addr_bus = a; slv_nak = nk;
        for (int i = 0; i < 6; i++) slv_data[i*32 +: 32] = $urandom;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0: return 32'hbfc00000 | ($urandom & 32'h00003ffc);
            1: return 32'hbfe00000 | ($urandom & 32'h001ffffc);
            2: return 32'hbfd00000 | ($urandom & 32'h00000ffc);
            3: return 32'hbfd01000 | ($urandom & 32'h00000ffc);
            4: return 32'hbfd02000 | ($urandom & 32'h00000ffc);
            5: return 32'hbfd10000 | ($urandom & 32'h0000fffc);
            6: return 32'hbfc0a000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic        en;
        logic [31:0] a;
        logic [5:0]  nk;
        model_reset();
        rst = 1'b1; master_en = 1'b0; addr_bus = '0; slv_nak = '0; slv_data = '0;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h0, 6'h00);

        // Back-to-back BIOS, gVRAM, GPIO then idle.
        drive(1'b0, 1'b1, 32'hbfc00010, 6'h00);
        drive(1'b0, 1'b1, 32'hbfe00020, 6'h00);
        drive(1'b0, 1'b1, 32'hbfd00004, 6'h00);
        drive(1'b0, 1'b0, 32'h0, 6'h00);
        // gVRAM stalled 3 cycles while a new address waits.
        drive(1'b0, 1'b1, 32'hbfe00040, 6'h00);
        repeat (3) drive(1'b0, 1'b1, 32'hbfd00008, 6'h02);
        drive(1'b0, 1'b1, 32'hbfd00008, 6'h00);
        drive(1'b0, 1'b0, 32'h0, 6'h00);
        // Unmapped access.
        drive(1'b0, 1'b1, 32'hbfc0a000, 6'h00);
        drive(1'b0, 1'b0, 32'h0, 6'h00);
        drive(1'b0, 1'b0, 32'h0, 6'h00);
        // Slave nak held: instance a aborts, instance b stalls on.
        drive(1'b0, 1'b1, 32'hbfc00100, 6'h00);
        repeat (8) drive(1'b0, 1'b1, 32'hbfc00100, 6'h3f);
        chk("nak_hold_nowd", 64'(b_nak), 64'd1);
        // Reset in the middle of the stall.
        drive(1'b1, 1'b1, 32'hbfc00100, 6'h3f);
        chk("nak_after_rst", 64'(b_nak), 64'd0);
        chk("errcnt_after_rst", 64'(b_cnt), 64'd0);
        drive(1'b0, 1'b0, 32'h0, 6'h00);

        // Randomised traffic honouring the hold-while-stalled rule.
        en = 1'b0; a = '0; nk = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!(mnak[0] || mnak[1])) begin
                en = ($urandom_range(0, 4) != 0);
                a  = rand_addr();
            end
            if ($urandom_range(0, 7) == 0) nk = 6'($urandom) & 6'($urandom);
            drive(($urandom_range(0, 199) == 0), en, a, nk);
        end

        // Counter saturation: five errors into a 2-bit counter.
        drive(1'b1, 1'b0, 32'h0, 6'h00);
        repeat (5) begin
            drive(1'b0, 1'b1, 32'hbfc0a000, 6'h00);
            drive(1'b0, 1'b0, 32'h0, 6'h00);
        end
        drive(1'b0, 1'b0, 32'h0, 6'h00);
        chk("errcnt_sat", 64'(a_cnt), 64'd3);
        chk("errcnt_wide", 64'(b_cnt), 64'd5);
        chk("errcode_unmapped", 64'(a_code), 64'd1);
        chk("erraddr_unmapped", 64'(a_eaddr), 64'hbfc0a000);

        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
